// File: rtl/ats21_pkg.sv
// ATS21 host-command receiver: shared types and constants.
// TIMEOUT applies only when ATS21_RX_TIMEOUT_EN is defined.
package ats21_pkg;

  localparam int TIMEOUT = 16;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_SETCLK = 3'b001,
    OP_BCEN   = 3'b010,
    OP_MODE   = 3'b011,
    OP_RSVD   = 3'b100,
    OP_ALARM  = 3'b101,
    OP_CNTDN  = 3'b110,
    OP_ATEN   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_OK  = 2'b00,
    ST_ACC = 2'b01,
    ST_ILL = 2'b10,
    ST_ERR = 2'b11
  } stat_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT2,
    S_DISP_A,
    S_DISP_B
  } rx_state_t;

  typedef struct packed {
    op_e         op;
    logic [3:0]  clk_id;
    logic [4:0]  at_id;
    logic [1:0]  rate;
    logic        flag;
    logic [3:0]  perm;
    logic [15:0] data;
  } ats21_cmd_t;

  // Protocol error outranks illegal opcode, which outranks acceptance.
  function automatic stat_e classify(
    input logic proto,
    input logic ill,
    input logic any_q
  );
    stat_e s;
    if (proto)      s = ST_ERR;
    else if (ill)   s = ST_ILL;
    else if (any_q) s = ST_ACC;
    else            s = ST_OK;
    return s;
  endfunction

endpackage

// File: rtl/ats21_cmd_decode.sv
// ATS21 instruction decoder: {hi,lo} word pair to command fields.
// Purely combinational; one instance per client.
import ats21_pkg::*;

module ats21_cmd_decode (
  input  logic [15:0] hi,
  input  logic [15:0] lo,
  output ats21_cmd_t  cmd,
  output logic        legal,
  output logic        nop
);

  logic unused_bits;
  assign unused_bits = ^hi[5:4];

  always_comb begin
    cmd    = '0;
    cmd.op = op_e'(hi[15:13]);
    unique case (cmd.op)
      OP_SETCLK: begin
        cmd.clk_id = hi[12:9];
        cmd.rate   = hi[7:6];
      end
      OP_BCEN: begin
        cmd.clk_id = hi[12:9];
        cmd.flag   = hi[7];
      end
      OP_MODE: begin
        cmd.flag = hi[12];
        cmd.perm = hi[11:8];
      end
      OP_ALARM: begin
        cmd.at_id  = hi[12:8];
        cmd.flag   = hi[7];
        cmd.clk_id = hi[3:0];
        cmd.data   = lo;
      end
      OP_CNTDN: begin
        cmd.at_id  = hi[12:8];
        cmd.clk_id = hi[3:0];
        cmd.data   = lo;
      end
      OP_ATEN: begin
        cmd.at_id = hi[12:8];
        cmd.flag  = hi[7];
      end
      default: ;
    endcase
  end

  assign legal = (cmd.op != OP_RSVD);
  assign nop   = (cmd.op == OP_NOP);

endmodule

// File: rtl/ats21_cmd_rx.sv
// ATS21 host-command receiver: 2-beat capture, A-then-B dispatch.
// Define ATS21_RX_TIMEOUT_EN to drop commands stalled for TIMEOUT cycles.
import ats21_pkg::*;

module ats21_cmd_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] ctrlA,
  input  logic [15:0] ctrlB,
  output logic        ready,
  output logic [1:0]  stat,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_client,
  output logic [2:0]  cmd_op,
  output logic [3:0]  cmd_clk_id,
  output logic [4:0]  cmd_at_id,
  output logic [1:0]  cmd_rate,
  output logic        cmd_flag,
  output logic [3:0]  cmd_perm,
  output logic [15:0] cmd_data
);

  rx_state_t  state;
  stat_e      stat_q;
  ats21_cmd_t cmd_q;

  logic [15:0] hi_a_q;
  logic [15:0] hi_b_q;
  logic [15:0] lo_a_q;
  logic [15:0] lo_b_q;
  logic [15:0] lo_a;
  logic [15:0] lo_b;
  logic        q_b;

  ats21_cmd_t dec_a;
  ats21_cmd_t dec_b;
  logic       legal_a;
  logic       legal_b;
  logic       nop_a;
  logic       nop_b;
  logic       want_a;
  logic       want_b;
  logic       expire;
  logic       adv;

  // Low words are consumed live in BEAT2 so A can be presented next cycle.
  assign lo_a = (state == S_BEAT2) ? ctrlA : lo_a_q;
  assign lo_b = (state == S_BEAT2) ? ctrlB : lo_b_q;

  ats21_cmd_decode u_dec_a (
    .hi    (hi_a_q),
    .lo    (lo_a),
    .cmd   (dec_a),
    .legal (legal_a),
    .nop   (nop_a)
  );

  ats21_cmd_decode u_dec_b (
    .hi    (hi_b_q),
    .lo    (lo_b),
    .cmd   (dec_b),
    .legal (legal_b),
    .nop   (nop_b)
  );

  assign want_a = legal_a && !nop_a;
  assign want_b = legal_b && !nop_b;

`ifdef ATS21_RX_TIMEOUT_EN
  logic [7:0] wait_cnt;

  assign expire = cmd_valid && !cmd_ready &&
                  (wait_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (adv || !cmd_valid) begin
      wait_cnt <= '0;
    end else if (!cmd_ready) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  assign adv = !cmd_valid || cmd_ready || expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      stat_q     <= ST_OK;
      cmd_valid  <= 1'b0;
      cmd_client <= 1'b0;
      cmd_q      <= '0;
      hi_a_q     <= '0;
      hi_b_q     <= '0;
      lo_a_q     <= '0;
      lo_b_q     <= '0;
      q_b        <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            hi_a_q <= ctrlA;
            hi_b_q <= ctrlB;
            ready  <= 1'b0;
            stat_q <= ST_OK;
            state  <= S_BEAT2;
          end
        end
        S_BEAT2: begin
          lo_a_q     <= ctrlA;
          lo_b_q     <= ctrlB;
          q_b        <= want_b;
          stat_q     <= classify(req, !legal_a || !legal_b,
                                 want_a || want_b);
          cmd_valid  <= want_a;
          cmd_client <= 1'b0;
          cmd_q      <= want_a ? dec_a : '0;
          state      <= S_DISP_A;
        end
        S_DISP_A: begin
          if (req || expire) stat_q <= ST_ERR;
          if (adv) begin
            cmd_valid  <= q_b;
            cmd_client <= q_b;
            cmd_q      <= q_b ? dec_b : '0;
            state      <= S_DISP_B;
          end
        end
        S_DISP_B: begin
          if (req || expire) stat_q <= ST_ERR;
          if (adv) begin
            cmd_valid  <= 1'b0;
            cmd_client <= 1'b0;
            cmd_q      <= '0;
            q_b        <= 1'b0;
            ready      <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stat       = stat_q;
  assign cmd_op     = cmd_q.op;
  assign cmd_clk_id = cmd_q.clk_id;
  assign cmd_at_id  = cmd_q.at_id;
  assign cmd_rate   = cmd_q.rate;
  assign cmd_flag   = cmd_q.flag;
  assign cmd_perm   = cmd_q.perm;
  assign cmd_data   = cmd_q.data;

endmodule

// File: tb/tb_ats21_cmd_rx.sv
// Bench for ats21_cmd_rx: queue model of expected dispatches
// plus directed literal checks on timing, stat and reset.
module tb_ats21_cmd_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [15:0] ctrlA = '0;
  logic [15:0] ctrlB = '0;
  logic        ready;
  logic [1:0]  stat;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        cmd_client;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_clk_id;
  logic [4:0]  cmd_at_id;
  logic [1:0]  cmd_rate;
  logic        cmd_flag;
  logic [3:0]  cmd_perm;
  logic [15:0] cmd_data;

  int total = 0;
  int bad = 0;
  int stall = 0;
  logic [35:0] expq[$];

  ats21_cmd_rx dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .ctrlA      (ctrlA),
    .ctrlB      (ctrlB),
    .ready      (ready),
    .stat       (stat),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_client (cmd_client),
    .cmd_op     (cmd_op),
    .cmd_clk_id (cmd_clk_id),
    .cmd_at_id  (cmd_at_id),
    .cmd_rate   (cmd_rate),
    .cmd_flag   (cmd_flag),
    .cmd_perm   (cmd_perm),
    .cmd_data   (cmd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [35:0] act,
                       input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Field layout: client, op, clk, at, rate, flag, perm, data.
  function automatic logic [35:0] model_cmd(input logic c,
                                            input logic [15:0] hi,
                                            input logic [15:0] lo);
    logic [2:0]  op;
    logic [3:0]  ck;
    logic [4:0]  at;
    logic [1:0]  rt;
    logic        fl;
    logic [3:0]  pm;
    logic [15:0] dt;
    op = hi[15:13];
    ck = 0; at = 0; rt = 0; fl = 0; pm = 0; dt = 0;
    if (op == 1 || op == 2) ck = hi[12:9];
    if (op == 5 || op == 6) begin ck = hi[3:0]; dt = lo; end
    if (op >= 5) at = hi[12:8];
    if (op == 1) rt = hi[7:6];
    if (op == 2 || op == 5 || op == 7) fl = hi[7];
    if (op == 3) begin fl = hi[12]; pm = hi[11:8]; end
    return {c, op, ck, at, rt, fl, pm, dt};
  endfunction

  function automatic bit dispatched(input logic [15:0] hi);
    return hi[15:13] != 3'd0 && hi[15:13] != 3'd4;
  endfunction

  wire [35:0] dut_vec = {cmd_client, cmd_op, cmd_clk_id, cmd_at_id,
                         cmd_rate, cmd_flag, cmd_perm, cmd_data};

  always @(negedge clk) begin
    if (!reset && cmd_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid: got %h want none", dut_vec);
      end else begin
        check("model_cmd", dut_vec, expq[0]);
        if (cmd_ready) begin
          void'(expq.pop_front());
          stall = 0;
        end else begin
          stall++;
`ifdef ATS21_RX_TIMEOUT_EN
          if (stall == 16) begin
            void'(expq.pop_front());
            stall = 0;
          end
`endif
        end
      end
    end
  end

  // Called just after a posedge; returns just after the edge that
  // makes A visible (cycle N+2 relative to the req cycle N).
  task automatic send(input logic [15:0] ha, input logic [15:0] hb,
                      input logic [15:0] la, input logic [15:0] lb,
                      input bit proto);
    if (dispatched(ha)) expq.push_back(model_cmd(1'b0, ha, la));
    if (dispatched(hb)) expq.push_back(model_cmd(1'b1, hb, lb));
    stall = 0;
    req = 1'b1; ctrlA = ha; ctrlB = hb;
    @(posedge clk); #1;
    req = proto; ctrlA = la; ctrlB = lb;
    @(posedge clk); #1;
    req = 1'b0; ctrlA = '0; ctrlB = '0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!ready) begin
      bad++;
      $display("FAIL %s: ready stuck at 0 after %0d cycles", name, n);
    end
    check({name, "_drained"}, 36'(expq.size()), 36'd0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", 36'(ready), 36'd1);
    check("rst_stat", 36'(stat), 36'd0);
    check("rst_valid", 36'(cmd_valid), 36'd0);
    check("rst_data", 36'(cmd_data), 36'd0);
    @(posedge clk); #1;

    // Two SETCLKs, core always ready.
    cmd_ready = 1'b1;
    send(16'h2000, 16'h2240, 16'h0, 16'h0, 0);
    check("t1_valid_n2", 36'(cmd_valid), 36'd1);
    check("t1_a_client", 36'(cmd_client), 36'd0);
    check("t1_a_op", 36'(cmd_op), 36'd1);
    check("t1_a_rate", 36'(cmd_rate), 36'd0);
    check("t1_ready_n2", 36'(ready), 36'd0);
    @(posedge clk); #1;
    check("t1_b_client", 36'(cmd_client), 36'd1);
    check("t1_b_clk", 36'(cmd_clk_id), 36'd1);
    check("t1_b_rate", 36'(cmd_rate), 36'd1);
    check("t1_stat", 36'(stat), 36'd1);
    @(posedge clk); #1;
    check("t1_ready_n4", 36'(ready), 36'd1);
    check("t1_valid_n4", 36'(cmd_valid), 36'd0);
    wait_ready("t1");

    // ALARM from A, nop from B.
    send(16'hA382, 16'h0000, 16'h1234, 16'hFFFF, 0);
    check("t2_op", 36'(cmd_op), 36'd5);
    check("t2_at", 36'(cmd_at_id), 36'd3);
    check("t2_flag", 36'(cmd_flag), 36'd1);
    check("t2_clk", 36'(cmd_clk_id), 36'd2);
    check("t2_data", 36'(cmd_data), 36'h1234);
    @(posedge clk); #1;
    check("t2_b_skipped", 36'(cmd_valid), 36'd0);
    wait_ready("t2");
    check("t2_stat", 36'(stat), 36'd1);

    // Illegal A, ATEN from B: A slot burns one empty cycle.
    send(16'h8000, 16'hEA80, 16'h0, 16'h0, 0);
    check("t3_stat", 36'(stat), 36'd2);
    check("t3_a_empty", 36'(cmd_valid), 36'd0);
    @(posedge clk); #1;
    check("t3_b_valid", 36'(cmd_valid), 36'd1);
    check("t3_b_client", 36'(cmd_client), 36'd1);
    check("t3_b_op", 36'(cmd_op), 36'd7);
    check("t3_b_at", 36'(cmd_at_id), 36'd10);
    wait_ready("t3");

    // MODE from A, BCEN from B.
    send(16'h7900, 16'h4680, 16'h0, 16'h0, 0);
    check("t4_perm", 36'(cmd_perm), 36'd9);
    check("t4_flag", 36'(cmd_flag), 36'd1);
    wait_ready("t4");

    // Both nop: nothing dispatched, stat 00.
    send(16'h0000, 16'h0000, 16'h0, 16'h0, 0);
    check("t5_stat", 36'(stat), 36'd0);
    wait_ready("t5");

    // Stall with a stray req mid-wait.
    cmd_ready = 1'b0;
    send(16'h2000, 16'h2240, 16'h0, 16'h0, 0);
    for (int i = 0; i < 10; i++) begin
      check("t6_hold_valid", 36'(cmd_valid), 36'd1);
      check("t6_hold_client", 36'(cmd_client), 36'd0);
      if (i == 4) check("t6_stray_stat", 36'(stat), 36'd3);
      req = (i == 3);
      ctrlA = (i == 3) ? 16'hE000 : 16'h0;
      @(posedge clk); #1;
    end
    req = 1'b0;
    cmd_ready = 1'b1;
    wait_ready("t6");
    check("t6_stat_held", 36'(stat), 36'd3);

    // req still high in beat 2: protocol error, commands still run.
    send(16'hC105, 16'h0000, 16'h00AA, 16'h0, 1);
    check("t7_stat", 36'(stat), 36'd3);
    check("t7_data", 36'(cmd_data), 36'h00AA);
    wait_ready("t7");

`ifdef ATS21_RX_TIMEOUT_EN
    cmd_ready = 1'b0;
    send(16'h2000, 16'h2240, 16'h0, 16'h0, 0);
    repeat (16) begin
      @(posedge clk); #1;
    end
    check("to_b_client", 36'(cmd_client), 36'd1);
    check("to_stat", 36'(stat), 36'd3);
    cmd_ready = 1'b1;
    wait_ready("to");
`endif

    // Reset during a stalled dispatch.
    cmd_ready = 1'b0;
    send(16'h2000, 16'h2240, 16'h0, 16'h0, 0);
    check("t8_pre_valid", 36'(cmd_valid), 36'd1);
    reset = 1'b1;
    expq.delete();
    @(posedge clk); #1;
    check("t8_valid", 36'(cmd_valid), 36'd0);
    check("t8_ready", 36'(ready), 36'd1);
    check("t8_stat", 36'(stat), 36'd0);
    reset = 1'b0;
    cmd_ready = 1'b1;
    @(posedge clk); #1;

    // Normal traffic after reset.
    send(16'hC105, 16'h2240, 16'h0777, 16'h0, 0);
    wait_ready("t9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
